// File: rtl/grid_cmd_exec_pkg.sv
// Shared types for the grid command executor: command opcodes, FSM states
// and the column-shift helper used to build cell addresses without a multiplier.
package grid_cmd_pkg;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'd0,
        OP_READ     = 2'd1,
        OP_FILL_ALL = 2'd2,
        OP_FILL_ROW = 2'd3
    } grid_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_SWEEP,
        ST_FINISH
    } state_e;

    // GRID_W is a power of two, so y*GRID_W is y shifted left by this amount.
    function automatic int col_shift(input int grid_w);
        return $clog2(grid_w);
    endfunction

endpackage

// File: rtl/grid_cmd_exec_if.sv
// Command handshake from the register file and the single-port cell RAM bus.
interface grid_cmd_if #(
    parameter int COORD_BITS = 8,
    parameter int CELL_BITS  = 8
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    grid_cmd_pkg::grid_op_e   cmd_op;
    logic [COORD_BITS-1:0]    cmd_x;
    logic [COORD_BITS-1:0]    cmd_y;
    logic [CELL_BITS-1:0]     cmd_val;

    modport master (output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_val, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_x, cmd_y, cmd_val, output cmd_ready);
endinterface

interface grid_mem_if #(
    parameter int ADDR_BITS = 10,
    parameter int CELL_BITS = 8
);
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [CELL_BITS-1:0] mem_wdata;
    logic [CELL_BITS-1:0] mem_rdata;

    modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/grid_cmd_exec_sweep.sv
// Address sweeper: loaded with a first/last address, steps by one per advance
// and flags the terminal address. Single-cell commands load first == last.
module grid_addr_sweep #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 advance_i,
    input  logic [ADDR_BITS-1:0] start_i,
    input  logic [ADDR_BITS-1:0] end_i,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic                 last_o
);

    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] end_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            end_q  <= '0;
        end else if (load_i) begin
            addr_q <= start_i;
            end_q  <= end_i;
        end else if (advance_i) begin
            addr_q <= addr_q + ADDR_BITS'(1);
        end
    end

    assign addr_o = addr_q;
    assign last_o = (addr_q == end_q);

endmodule

// File: rtl/grid_cmd_exec.sv
// Executes grid commands (write, read, fill-all, fill-row) against a cell RAM.
// Optional GRID_CMD_STATS_EN adds command and error counters.
module grid_cmd_exec
    import grid_cmd_pkg::*;
#(
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 24,
    parameter int CELL_BITS  = 8,
    parameter int COORD_BITS = 8,
    parameter int ADDR_BITS  = 10
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    grid_cmd_if.slave            cmd,
    grid_mem_if.master           mem,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CELL_BITS-1:0] rd_data,
    output logic                 rd_valid
`ifdef GRID_CMD_STATS_EN
    ,
    output logic [31:0]          cmd_count,
    output logic [15:0]          err_count
`endif
);

    localparam int COL_BITS = col_shift(GRID_W);
    localparam logic [ADDR_BITS-1:0] LAST_CELL = ADDR_BITS'(GRID_W * GRID_H - 1);

    state_e               state_q, state_d;
    logic [CELL_BITS-1:0] val_q;
    logic [CELL_BITS-1:0] rd_q;
    logic                 err_q, err_d;

    logic                 accept, in_range, err_evt;
    logic                 mem_en, mem_we;
    logic [ADDR_BITS-1:0] cell_addr, row_first, row_last;
    logic [ADDR_BITS-1:0] start_addr, end_addr, sweep_addr;
    logic                 sweep_last;

    assign accept    = cmd.cmd_valid && cmd.cmd_ready;
    assign cell_addr = ADDR_BITS'({cmd.cmd_y, cmd.cmd_x[COL_BITS-1:0]});
    assign row_first = ADDR_BITS'({cmd.cmd_y, {COL_BITS{1'b0}}});
    assign row_last  = ADDR_BITS'({cmd.cmd_y, {COL_BITS{1'b1}}});

    always_comb begin
        in_range   = 1'b1;
        start_addr = cell_addr;
        end_addr   = cell_addr;
        case (cmd.cmd_op)
            OP_WRITE, OP_READ: in_range = (32'(cmd.cmd_x) < GRID_W) && (32'(cmd.cmd_y) < GRID_H);
            OP_FILL_ROW: begin
                in_range   = (32'(cmd.cmd_y) < GRID_H);
                start_addr = row_first;
                end_addr   = row_last;
            end
            OP_FILL_ALL: begin
                start_addr = '0;
                end_addr   = LAST_CELL;
            end
        endcase
    end

    assign err_evt = accept && !in_range;
    assign err_d   = err_evt || (err_q && !err_clr);

    grid_addr_sweep #(.ADDR_BITS(ADDR_BITS)) u_sweep (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .load_i    (accept && in_range),
        .advance_i (state_q == ST_SWEEP),
        .start_i   (start_addr),
        .end_i     (end_addr),
        .addr_o    (sweep_addr),
        .last_o    (sweep_last)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_range)                 state_d = ST_FINISH;
                    else if (cmd.cmd_op == OP_WRITE) state_d = ST_WRITE;
                    else if (cmd.cmd_op == OP_READ)  state_d = ST_RD_ISSUE;
                    else                           state_d = ST_SWEEP;
                end
            end
            ST_WRITE: begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                state_d = ST_FINISH;
            end
            ST_RD_ISSUE: begin
                mem_en  = 1'b1;
                state_d = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: state_d = ST_FINISH;
            ST_SWEEP: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
                if (sweep_last) state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            val_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept)   val_q <= cmd.cmd_val;
            if (rd_valid) rd_q  <= mem.mem_rdata;
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FINISH);
    assign err           = err_q;
    assign rd_valid      = (state_q == ST_RD_CAPTURE);
    // Read data is live during the capture cycle, then held from the register.
    assign rd_data       = rd_valid ? mem.mem_rdata : rd_q;

    assign mem.mem_en    = mem_en;
    assign mem.mem_we    = mem_we;
    assign mem.mem_addr  = mem_en ? sweep_addr : '0;
    assign mem.mem_wdata = mem_we ? val_q : '0;

`ifdef GRID_CMD_STATS_EN
    logic [31:0] cmd_count_q;
    logic [15:0] err_count_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (done) cmd_count_q <= cmd_count_q + 32'd1;
            if (err_evt && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
        end
    end

    assign cmd_count = cmd_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_grid_cmd_exec.sv
// Self-checking bench for grid_cmd_exec: directed scenarios plus random commands
// compared against a cell-array reference model and expected access timeline.
module tb_grid_cmd_exec;
    import grid_cmd_pkg::*;

    localparam int GRID_W = 32;
    localparam int GRID_H = 24;
    localparam int CELLS  = GRID_W * GRID_H;

    typedef struct {
        int         cyc;
        int         addr;
        bit         we;
        logic [7:0] data;
    } acc_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rd_t;

    logic ACLK = 1'b0;
    logic ARESETN;
    logic err_clr;
    logic busy, done, err, rd_valid;
    logic [7:0] rd_data;
`ifdef GRID_CMD_STATS_EN
    logic [31:0] cmd_count;
    logic [15:0] err_count;
`endif

    grid_cmd_if #(.COORD_BITS(8), .CELL_BITS(8)) cmd_bus ();
    grid_mem_if #(.ADDR_BITS(10), .CELL_BITS(8)) mem_bus ();

    grid_cmd_exec #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_BITS(8), .COORD_BITS(8), .ADDR_BITS(10)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .cmd      (cmd_bus),
        .mem      (mem_bus),
        .err_clr  (err_clr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`ifdef GRID_CMD_STATS_EN
        ,
        .cmd_count(cmd_count),
        .err_count(err_count)
`endif
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [7:0] ram     [0:1023];
    logic [7:0] exp_ram [0:1023];
    always @(posedge ACLK) begin
        if (mem_bus.mem_en && mem_bus.mem_we) ram[mem_bus.mem_addr] = mem_bus.mem_wdata;
        if (mem_bus.mem_en && !mem_bus.mem_we) mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
    end

    acc_t got_q[$], exp_q[$];
    rd_t  got_rd[$], exp_rd[$];
    int   done_got[$], done_exp[$];
    bit   exp_err = 1'b0;
    int   exp_cmd = 0;
    int   exp_errc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (mem_bus.mem_en) got_q.push_back('{cyc, int'(mem_bus.mem_addr), mem_bus.mem_we, mem_bus.mem_wdata});
            if (done)           done_got.push_back(cyc);
            if (rd_valid)       got_rd.push_back('{cyc, rd_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ram_mismatches();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== exp_ram[i]) n++;
        return n;
    endfunction

    // Reference model: expected RAM accesses, done/read timing and err from the command rules.
    task automatic model(input grid_op_e op, input int x, input int y, input logic [7:0] val,
                         input bit clr, input int acc);
        bit ok;
        int a;
        case (op)
            OP_WRITE, OP_READ: ok = (x < GRID_W) && (y < GRID_H);
            OP_FILL_ROW:       ok = (y < GRID_H);
            default:           ok = 1'b1;
        endcase
        exp_cmd++;
        if (!ok) begin
            exp_err = 1'b1;
            exp_errc++;
            done_exp.push_back(acc + 1);
            return;
        end
        if (clr) exp_err = 1'b0;
        a = y * GRID_W + x;
        case (op)
            OP_WRITE: begin
                exp_q.push_back('{acc + 1, a, 1'b1, val});
                exp_ram[a] = val;
                done_exp.push_back(acc + 2);
            end
            OP_READ: begin
                exp_q.push_back('{acc + 1, a, 1'b0, 8'h00});
                exp_rd.push_back('{acc + 2, exp_ram[a]});
                done_exp.push_back(acc + 3);
            end
            OP_FILL_ROW: begin
                for (int i = 0; i < GRID_W; i++) begin
                    exp_q.push_back('{acc + 1 + i, y * GRID_W + i, 1'b1, val});
                    exp_ram[y * GRID_W + i] = val;
                end
                done_exp.push_back(acc + GRID_W + 1);
            end
            default: begin
                for (int i = 0; i < CELLS; i++) begin
                    exp_q.push_back('{acc + 1 + i, i, 1'b1, val});
                    exp_ram[i] = val;
                end
                done_exp.push_back(acc + CELLS + 1);
            end
        endcase
    endtask

    task automatic drive(input grid_op_e op, input int x, input int y, input logic [7:0] val, input bit clr);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_x     = x[7:0];
        cmd_bus.cmd_y     = y[7:0];
        cmd_bus.cmd_val   = val;
        err_clr           = clr;
    endtask

    task automatic issue(input grid_op_e op, input int x, input int y, input logic [7:0] val,
                         input bit clr, output int acc);
        int n = 0;
        @(negedge ACLK);
        while (!cmd_bus.cmd_ready && n < 3000) begin
            @(negedge ACLK);
            n++;
        end
        check("ready_wait", cmd_bus.cmd_ready, 1'b1);
        drive(op, x, y, val, clr);
        acc = cyc;
        model(op, x, y, val, clr, acc);
        @(negedge ACLK);
        cmd_bus.cmd_valid = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((done_got.size() < done_exp.size() || !cmd_bus.cmd_ready) && n < 3000) begin
            @(negedge ACLK);
            n++;
        end
        repeat (2) @(negedge ACLK);
    endtask

    task automatic compare(input string tag);
        check({tag, "_n_access"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_acc_cycle"}, got_q[i].cyc, exp_q[i].cyc);
            check({tag, "_acc_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_acc_we"}, got_q[i].we, exp_q[i].we);
            if (exp_q[i].we) check({tag, "_acc_wdata"}, got_q[i].data, exp_q[i].data);
        end
        check({tag, "_n_done"}, done_got.size(), done_exp.size());
        for (int i = 0; i < done_exp.size() && i < done_got.size(); i++)
            check({tag, "_done_cycle"}, done_got[i], done_exp[i]);
        check({tag, "_n_rd_valid"}, got_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
            check({tag, "_rd_cycle"}, got_rd[i].cyc, exp_rd[i].cyc);
            check({tag, "_rd_data"}, got_rd[i].data, exp_rd[i].data);
        end
        check({tag, "_err"}, err, exp_err);
        check({tag, "_idle_busy"}, busy, 1'b0);
        got_q.delete();  exp_q.delete();
        got_rd.delete(); exp_rd.delete();
        done_got.delete(); done_exp.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    cmd_bus.cmd_ready, 1'b1);
        check({tag, "_busy"},     busy, 1'b0);
        check({tag, "_done"},     done, 1'b0);
        check({tag, "_err"},      err, 1'b0);
        check({tag, "_rd_valid"}, rd_valid, 1'b0);
        check({tag, "_rd_data"},  rd_data, 8'h00);
        check({tag, "_mem_en"},   mem_bus.mem_en, 1'b0);
        check({tag, "_mem_we"},   mem_bus.mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_bus.mem_addr, 10'd0);
        check({tag, "_mem_wdata"}, mem_bus.mem_wdata, 8'h00);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n;
        int x, y;
        grid_op_e op;
        logic [7:0] v;
        bit clr;
        logic [7:0] snap [0:1023];

        ARESETN = 1'b0;
        err_clr = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op = OP_WRITE;
        cmd_bus.cmd_x = '0;
        cmd_bus.cmd_y = '0;
        cmd_bus.cmd_val = '0;
        for (int i = 0; i < 1024; i++) begin
            v = 8'($urandom);
            ram[i] = v;
            exp_ram[i] = v;
        end

        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        ARESETN = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("post_reset");

        // Single write then read-back of the same cell.
        issue(OP_WRITE, 3, 2, 8'hA5, 1'b0, acc);
        wait_done();
        compare("write_3_2");
        issue(OP_READ, 3, 2, 8'h00, 1'b0, acc);
        wait_done();
        compare("read_3_2");
        check("read_held", rd_data, 8'hA5);
        check("ram_after_read", ram_mismatches(), 0);

        // Row fill with a second command held valid throughout the sweep.
        issue(OP_FILL_ROW, 0, 23, 8'h0F, 1'b0, acc);
        drive(OP_WRITE, 5, 1, 8'h3C, 1'b0);
        n = 0;
        while (!cmd_bus.cmd_ready && n < 3000) begin
            @(negedge ACLK);
            n++;
        end
        acc2 = cyc;
        check("held_accept_cycle", acc2, acc + GRID_W + 2);
        model(OP_WRITE, 5, 1, 8'h3C, 1'b0, acc2);
        @(negedge ACLK);
        cmd_bus.cmd_valid = 1'b0;
        wait_done();
        compare("fill_row_23");
        check("ram_after_row", ram_mismatches(), 0);

        // Range errors and err_clr priority.
        issue(OP_WRITE, 32, 0, 8'h77, 1'b0, acc);
        wait_done();
        compare("err_write_x32");
        issue(OP_READ, 0, 24, 8'h00, 1'b1, acc);
        wait_done();
        compare("err_read_y24_with_clr");
        @(negedge ACLK);
        err_clr = 1'b1;
        @(negedge ACLK);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_clr_alone", err, exp_err);
        issue(OP_FILL_ROW, 7, 30, 8'h55, 1'b0, acc);
        wait_done();
        compare("err_fill_row_y30");
        check("ram_after_errors", ram_mismatches(), 0);

        // Random commands, including out-of-range coordinates.
        for (int i = 0; i < 14; i++) begin
            op  = grid_op_e'(2'($urandom_range(3, 0)));
            x   = $urandom_range(35, 0);
            y   = $urandom_range(27, 0);
            v   = 8'($urandom);
            clr = ($urandom_range(3, 0) == 0);
            issue(op, x, y, v, clr, acc);
            wait_done();
            compare("random");
        end
        check("ram_after_random", ram_mismatches(), 0);

`ifdef GRID_CMD_STATS_EN
        check("cmd_count", cmd_count, 32'(exp_cmd));
        check("err_count", err_count, 16'(exp_errc));
`endif

        // Fill-all aborted by reset after the 100th write.
        for (int i = 0; i < 1024; i++) snap[i] = exp_ram[i];
        issue(OP_FILL_ALL, 0, 0, 8'h11, 1'b0, acc);
        while (exp_q.size() > 100) void'(exp_q.pop_back());
        done_exp.delete();
        for (int i = 100; i < 1024; i++) exp_ram[i] = snap[i];
        n = 0;
        while (cyc < acc + 100 && n < 3000) begin
            @(negedge ACLK);
            n++;
        end
        @(posedge ACLK);
        #1 ARESETN = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_err  = 1'b0;
        exp_cmd  = 0;
        exp_errc = 0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        compare("fill_all_reset");
        check("ram_after_abort", ram_mismatches(), 0);

        issue(OP_READ, 4, 3, 8'h00, 1'b0, acc);
        wait_done();
        compare("read_untouched_100");
        issue(OP_READ, 3, 1, 8'h00, 1'b0, acc);
        wait_done();
        compare("read_filled_35");

`ifdef GRID_CMD_STATS_EN
        check("cmd_count_after_reset", cmd_count, 32'(exp_cmd));
        check("err_count_after_reset", err_count, 16'(exp_errc));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
